executor_core: RTL and testbench

EXECUTOR_CORE -- requirements
Module: executor_core

---
 rtl/executor_core_pkg.sv | 69 ++++++
 rtl/executor_core_if.sv | 22 ++
 rtl/executor_core_alu.sv | 30 +++
 rtl/executor_core.sv | 165 ++++++++++++++++
 tb/tb_executor_core.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/executor_core_pkg.sv
// Shared definitions for the executor core: bus widths, opcodes, access widths
// and small decode helpers used by the core, the ALU and the bench.
package executor_core_pkg;

    localparam int ADDR_BUS = 32;
    localparam int DATA_BUS = 32;

    localparam logic TRUE  = 1'b1;
    localparam logic FALSE = 1'b0;

    localparam logic [3:0] WIDTH_B = 4'd1;
    localparam logic [3:0] WIDTH_H = 4'd2;
    localparam logic [3:0] WIDTH_W = 4'd4;

    typedef enum logic [3:0] {
        OP_HALT = 4'd0,
        OP_ADD  = 4'd1,
        OP_SUB  = 4'd2,
        OP_AND  = 4'd3,
        OP_OR   = 4'd4,
        OP_XOR  = 4'd5,
        OP_ADDI = 4'd6,
        OP_LB   = 4'd7,
        OP_LH   = 4'd8,
        OP_LW   = 4'd9,
        OP_SB   = 4'd10,
        OP_SH   = 4'd11,
        OP_SW   = 4'd12,
        OP_BEQ  = 4'd13,
        OP_BNE  = 4'd14,
        OP_JMP  = 4'd15
    } opcode_t;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_EXEC,
        ST_DONE
    } state_t;

    function automatic logic [DATA_BUS-1:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

    function automatic logic is_load(input opcode_t op);
        return (op == OP_LB) || (op == OP_LH) || (op == OP_LW);
    endfunction

    function automatic logic is_store(input opcode_t op);
        return (op == OP_SB) || (op == OP_SH) || (op == OP_SW);
    endfunction

    function automatic logic [3:0] width_of(input opcode_t op);
        case (op)
            OP_LB, OP_SB: return WIDTH_B;
            OP_LH, OP_SH: return WIDTH_H;
            default:      return WIDTH_W;
        endcase
    endfunction

    function automatic logic [DATA_BUS-1:0] size_mask(input logic [3:0] width);
        case (width)
            WIDTH_B: return 32'h0000_00FF;
            WIDTH_H: return 32'h0000_FFFF;
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

endpackage

// File: rtl/executor_core_if.sv
// Memory bus between the executor core (master) and its program/data memory.
interface executor_core_if;
    import executor_core_pkg::*;

    logic                mem_ce_o;
    logic                mem_we_o;
    logic [ADDR_BUS-1:0] mem_addr_o;
    logic [3:0]          mem_width_o;
    logic [DATA_BUS-1:0] mem_data_o;
    logic [DATA_BUS-1:0] mem_data_i;

    modport master (
        output mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        input  mem_data_i
    );

    modport slave (
        input  mem_ce_o, mem_we_o, mem_addr_o, mem_width_o, mem_data_o,
        output mem_data_i
    );

endinterface

// File: rtl/executor_core_alu.sv
// Combinational ALU: register/immediate arithmetic and branch condition.
module executor_alu
    import executor_core_pkg::*;
(
    input  opcode_t             op,
    input  logic [DATA_BUS-1:0] a,
    input  logic [DATA_BUS-1:0] b,
    input  logic [DATA_BUS-1:0] imm,
    output logic [DATA_BUS-1:0] result,
    output logic                branch_taken
);

    always_comb begin
        result       = '0;
        branch_taken = FALSE;
        case (op)
            OP_ADD:  result = a + b;
            OP_SUB:  result = a - b;
            OP_AND:  result = a & b;
            OP_OR:   result = a | b;
            OP_XOR:  result = a ^ b;
            OP_ADDI: result = a + imm;
            OP_BEQ:  branch_taken = (a == b);
            OP_BNE:  branch_taken = (a != b);
            OP_JMP:  branch_taken = TRUE;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/executor_core.sv
// Two-cycle-per-instruction program executor with an 8-entry register file.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | out of reset, waiting for a start rising edge
// ST_FETCH | bus reads the word at pc, instruction is latched
// ST_EXEC  | ALU/branch/load/store in one cycle, pc updated
// ST_DONE  | HALT reached, ready_o high until next accepted start
module executor_core
    import executor_core_pkg::*;
#(
    parameter int NUM_REGS = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic [ADDR_BUS-1:0] start_addr_i,
    input  logic [ADDR_BUS-1:0] args_start_i,
    executor_core_if.master     bus,
    output logic                ready_o
);

    state_t              state;
    logic                start_q;
    logic [ADDR_BUS-1:0] pc;
    logic [DATA_BUS-1:0] rf [NUM_REGS];

    opcode_t             op_q;
    logic [2:0]          rd_q;
    logic [2:0]          rs1_q;
    logic [2:0]          rs2_q;
    logic [15:0]         imm_q;

    logic                ce_q;
    logic                we_q;
    logic [ADDR_BUS-1:0] addr_q;
    logic [3:0]          width_q;
    logic [DATA_BUS-1:0] wdata_q;

    opcode_t             f_op;
    logic [2:0]          f_rs1;
    logic [2:0]          f_rs2;
    logic [DATA_BUS-1:0] f_rs1_val;
    logic [DATA_BUS-1:0] f_rs2_val;
    logic [DATA_BUS-1:0] rs1_val;
    logic [DATA_BUS-1:0] rs2_val;
    logic [DATA_BUS-1:0] imm_ext;
    logic [DATA_BUS-1:0] alu_result;
    logic                branch_taken;
    logic [ADDR_BUS-1:0] next_pc;
    logic                writes_rd;
    logic [DATA_BUS-1:0] wb_data;
    logic                start_edge;

    assign start_edge = start_i & ~start_q;

    // Decode straight off the read bus in FETCH so load/store bus outputs
    // can be registered ready for the EXEC cycle.
    always_comb begin
        f_op      = opcode_t'(bus.mem_data_i[31:28]);
        f_rs1     = bus.mem_data_i[24:22];
        f_rs2     = bus.mem_data_i[21:19];
        f_rs1_val = (f_rs1 == 3'd0) ? '0 : rf[f_rs1];
        f_rs2_val = (f_rs2 == 3'd0) ? '0 : rf[f_rs2];
        rs1_val   = (rs1_q == 3'd0) ? '0 : rf[rs1_q];
        rs2_val   = (rs2_q == 3'd0) ? '0 : rf[rs2_q];
        imm_ext   = sext16(imm_q);
    end

    executor_alu u_alu (
        .op           (op_q),
        .a            (rs1_val),
        .b            (rs2_val),
        .imm          (imm_ext),
        .result       (alu_result),
        .branch_taken (branch_taken)
    );

    always_comb begin
        next_pc   = pc + 32'd4 + (branch_taken ? imm_ext : '0);
        writes_rd = ((op_q >= OP_ADD) && (op_q <= OP_ADDI)) || is_load(op_q);
        wb_data   = is_load(op_q) ? (bus.mem_data_i & size_mask(width_of(op_q)))
                                  : alu_result;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_IDLE;
            start_q <= FALSE;
            pc      <= '0;
            ready_o <= FALSE;
            op_q    <= OP_HALT;
            rd_q    <= '0;
            rs1_q   <= '0;
            rs2_q   <= '0;
            imm_q   <= '0;
            ce_q    <= FALSE;
            we_q    <= FALSE;
            addr_q  <= '0;
            width_q <= '0;
            wdata_q <= '0;
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else begin
            start_q <= start_i;
            ce_q    <= FALSE;
            we_q    <= FALSE;
            addr_q  <= '0;
            width_q <= '0;
            wdata_q <= '0;
            case (state)
                ST_IDLE, ST_DONE: begin
                    if (start_edge) begin
                        state   <= ST_FETCH;
                        pc      <= start_addr_i;
                        ready_o <= FALSE;
                        for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
                        rf[1]   <= args_start_i;
                        ce_q    <= TRUE;
                        addr_q  <= start_addr_i;
                        width_q <= WIDTH_W;
                    end
                end
                ST_FETCH: begin
                    state <= ST_EXEC;
                    op_q  <= f_op;
                    rd_q  <= bus.mem_data_i[27:25];
                    rs1_q <= f_rs1;
                    rs2_q <= f_rs2;
                    imm_q <= bus.mem_data_i[15:0];
                    if (is_load(f_op) || is_store(f_op)) begin
                        ce_q    <= TRUE;
                        we_q    <= is_store(f_op);
                        addr_q  <= f_rs1_val + sext16(bus.mem_data_i[15:0]);
                        width_q <= width_of(f_op);
                        if (is_store(f_op))
                            wdata_q <= f_rs2_val & size_mask(width_of(f_op));
                    end
                end
                ST_EXEC: begin
                    if (op_q == OP_HALT) begin
                        state   <= ST_DONE;
                        ready_o <= TRUE;
                    end else begin
                        state   <= ST_FETCH;
                        pc      <= next_pc;
                        ce_q    <= TRUE;
                        addr_q  <= next_pc;
                        width_q <= WIDTH_W;
                    end
                    if (writes_rd && (rd_q != 3'd0))
                        rf[rd_q] <= wb_data;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Masking with rst kills a store already queued for the reset cycle.
    assign bus.mem_ce_o    = ce_q & ~rst;
    assign bus.mem_we_o    = we_q & ~rst;
    assign bus.mem_addr_o  = rst ? '0 : addr_q;
    assign bus.mem_width_o = rst ? '0 : width_q;
    assign bus.mem_data_o  = rst ? '0 : wdata_q;

endmodule

// File: tb/tb_executor_core.sv
// Directed bench for executor_core with a little-endian byte memory model.
module tb_executor_core;
    import executor_core_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_i;
    logic [31:0] start_addr_i;
    logic [31:0] args_start_i;
    logic        ready_o;

    executor_core_if bus ();

    executor_core #(.NUM_REGS(8)) dut (
        .clk          (clk),
        .rst          (rst),
        .start_i      (start_i),
        .start_addr_i (start_addr_i),
        .args_start_i (args_start_i),
        .bus          (bus),
        .ready_o      (ready_o)
    );

    always #5 clk = ~clk;

    logic [7:0]  mem [0:1023];
    int          tests = 0;
    int          fails = 0;
    int          writes = 0;
    int          fetch68 = 0;
    int          cyc;
    logic [31:0] prog [$];

    always_comb begin
        logic [9:0] a;
        a = bus.mem_addr_o[9:0];
        bus.mem_data_i = '0;
        if (bus.mem_ce_o && !bus.mem_we_o) begin
            case (bus.mem_width_o)
                4'd1:    bus.mem_data_i = {24'h0, mem[a]};
                4'd2:    bus.mem_data_i = {16'h0, mem[a + 10'd1], mem[a]};
                default: bus.mem_data_i = {mem[a + 10'd3], mem[a + 10'd2],
                                           mem[a + 10'd1], mem[a]};
            endcase
        end
    end

    always @(posedge clk) begin
        if (bus.mem_ce_o && bus.mem_we_o) begin
            writes++;
            for (int k = 0; k < 4; k++)
                if (k < int'(bus.mem_width_o))
                    mem[bus.mem_addr_o[9:0] + 10'(k)] <= bus.mem_data_o[8*k +: 8];
        end
        if (bus.mem_ce_o && !bus.mem_we_o && bus.mem_width_o == 4'd4 &&
            bus.mem_addr_o == 32'd68)
            fetch68++;
    end

    function automatic logic [31:0] enc(input logic [3:0] op, input logic [2:0] rd,
                                        input logic [2:0] rs1, input logic [2:0] rs2,
                                        input int imm);
        return {op, rd, rs1, rs2, 3'b000, imm[15:0]};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic put_word(input int addr, input logic [31:0] w);
        for (int k = 0; k < 4; k++) mem[addr + k] = w[8*k +: 8];
    endtask

    function automatic logic [31:0] get_word(input int addr);
        return {mem[addr + 3], mem[addr + 2], mem[addr + 1], mem[addr]};
    endfunction

    task automatic load_prog(input int base);
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        foreach (prog[i]) put_word(base + 4 * i, prog[i]);
    endtask

    // Makes a fresh start edge and counts cycles from it until ready_o rises.
    task automatic run_prog(output int n);
        start_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        n = 0;
        while (ready_o !== 1'b1 && n < 300) begin
            tick();
            n++;
        end
    endtask

    initial begin
        rst          = 1'b1;
        start_i      = 1'b0;
        start_addr_i = 32'd64;
        args_start_i = 32'd128;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        tick();
        tick();
        check("rst_ready", {31'h0, ready_o}, 32'h0);
        check("rst_ce", {31'h0, bus.mem_ce_o}, 32'h0);
        check("rst_we", {31'h0, bus.mem_we_o}, 32'h0);
        check("rst_addr", bus.mem_addr_o, 32'h0);
        check("rst_width", {28'h0, bus.mem_width_o}, 32'h0);
        check("rst_data", bus.mem_data_o, 32'h0);
        rst = 1'b0;

        // HALT only: fetch cycle, empty exec cycle, ready two cycles after start
        prog = '{enc(OP_HALT, 0, 0, 0, 0)};
        load_prog(64);
        writes = 0;
        tick();
        start_i = 1'b1;
        tick();
        check("halt_fetch_ce", {31'h0, bus.mem_ce_o}, 32'h1);
        check("halt_fetch_we", {31'h0, bus.mem_we_o}, 32'h0);
        check("halt_fetch_addr", bus.mem_addr_o, 32'd64);
        check("halt_fetch_width", {28'h0, bus.mem_width_o}, 32'd4);
        check("halt_ready_early", {31'h0, ready_o}, 32'h0);
        tick();
        check("halt_exec_ce", {31'h0, bus.mem_ce_o}, 32'h0);
        check("halt_exec_addr", bus.mem_addr_o, 32'h0);
        tick();
        check("halt_ready", {31'h0, ready_o}, 32'h1);
        check("halt_writes", writes, 0);

        // start_i held high: no restart
        for (int i = 0; i < 5; i++) tick();
        check("hold_ready", {31'h0, ready_o}, 32'h1);
        check("hold_ce", {31'h0, bus.mem_ce_o}, 32'h0);
        start_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        check("restart_ready", {31'h0, ready_o}, 32'h0);
        check("restart_fetch", bus.mem_addr_o, 32'd64);
        tick();
        tick();
        check("restart_done", {31'h0, ready_o}, 32'h1);

        // ADDI/ADDI/SW/HALT
        prog = '{enc(OP_ADDI, 2, 0, 0, 5), enc(OP_ADDI, 3, 2, 0, -2),
                 enc(OP_SW, 0, 1, 3, 0), enc(OP_HALT, 0, 0, 0, 0)};
        load_prog(64);
        writes = 0;
        run_prog(cyc);
        check("addi_cycles", cyc, 8);
        check("addi_word128", get_word(128), 32'd3);
        check("addi_writes", writes, 1);

        // LB then SH, neighbours untouched
        prog = '{enc(OP_LB, 2, 1, 0, 1), enc(OP_SH, 0, 1, 2, 4), enc(OP_HALT, 0, 0, 0, 0)};
        load_prog(64);
        put_word(128, 32'h1122_3344);
        put_word(132, 32'hDDCC_BBAA);
        run_prog(cyc);
        check("lbsh_cycles", cyc, 6);
        check("lbsh_half132", {16'h0, mem[133], mem[132]}, 32'h0000_0033);
        check("lbsh_byte134", {24'h0, mem[134]}, 32'hCC);
        check("lbsh_byte135", {24'h0, mem[135]}, 32'hDD);
        check("lbsh_word128", get_word(128), 32'h1122_3344);

        // countdown loop, BNE taken twice
        prog = '{enc(OP_ADDI, 2, 0, 0, 3), enc(OP_ADDI, 2, 2, 0, -1),
                 enc(OP_BNE, 0, 2, 0, -8), enc(OP_SW, 0, 1, 2, 0), enc(OP_HALT, 0, 0, 0, 0)};
        load_prog(64);
        put_word(128, 32'hFFFF_FFFF);
        fetch68 = 0;
        run_prog(cyc);
        check("loop_cycles", cyc, 18);
        check("loop_word128", get_word(128), 32'h0);
        check("loop_fetch68", fetch68, 3);

        // ALU ops, r0 discard, JMP skip, LW, untaken BEQ
        args_start_i = 32'd512;
        prog = '{enc(OP_ADDI, 2, 0, 0, 12), enc(OP_ADDI, 3, 0, 0, 10),
                 enc(OP_ADD, 4, 2, 3, 0),   enc(OP_SW, 0, 1, 4, 0),
                 enc(OP_SUB, 4, 3, 2, 0),   enc(OP_SW, 0, 1, 4, 4),
                 enc(OP_AND, 4, 2, 3, 0),   enc(OP_SW, 0, 1, 4, 8),
                 enc(OP_OR, 4, 2, 3, 0),    enc(OP_SW, 0, 1, 4, 12),
                 enc(OP_XOR, 4, 2, 3, 0),   enc(OP_SW, 0, 1, 4, 16),
                 enc(OP_ADDI, 0, 0, 0, 7),  enc(OP_SW, 0, 1, 0, 20),
                 enc(OP_JMP, 0, 0, 0, 4),   enc(OP_SW, 0, 1, 2, 24),
                 enc(OP_LW, 5, 1, 0, 0),    enc(OP_SW, 0, 1, 5, 28),
                 enc(OP_BEQ, 0, 2, 3, 100), enc(OP_HALT, 0, 0, 0, 0)};
        load_prog(64);
        put_word(532, 32'hFFFF_FFFF);
        put_word(536, 32'hA5A5_A5A5);
        run_prog(cyc);
        check("alu_cycles", cyc, 38);
        check("alu_add", get_word(512), 32'd22);
        check("alu_sub", get_word(516), 32'hFFFF_FFFE);
        check("alu_and", get_word(520), 32'd8);
        check("alu_or", get_word(524), 32'd14);
        check("alu_xor", get_word(528), 32'd6);
        check("alu_r0", get_word(532), 32'h0);
        check("alu_jmp_skip", get_word(536), 32'hA5A5_A5A5);
        check("alu_lw", get_word(540), 32'd22);

        // reset during EXEC of SW
        args_start_i = 32'd128;
        prog = '{enc(OP_ADDI, 2, 0, 0, 9), enc(OP_SW, 0, 1, 2, 0), enc(OP_HALT, 0, 0, 0, 0)};
        load_prog(64);
        put_word(128, 32'h5555_5555);
        start_i = 1'b0;
        tick();
        start_i = 1'b1;
        tick();
        tick();
        tick();
        tick();
        check("sw_exec_we", {31'h0, bus.mem_we_o}, 32'h1);
        check("sw_exec_addr", bus.mem_addr_o, 32'd128);
        check("sw_exec_data", bus.mem_data_o, 32'd9);
        writes = 0;
        rst = 1'b1;
        start_i = 1'b0;
        tick();
        check("abort_word128", get_word(128), 32'h5555_5555);
        check("abort_writes", writes, 0);
        check("abort_ce", {31'h0, bus.mem_ce_o}, 32'h0);
        check("abort_addr", bus.mem_addr_o, 32'h0);
        check("abort_ready", {31'h0, ready_o}, 32'h0);
        rst = 1'b0;
        tick();
        tick();
        check("idle_after_abort_ce", {31'h0, bus.mem_ce_o}, 32'h0);
        check("idle_after_abort_wr", writes, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
